// File: rtl/pipeline_pkg.sv
// Shared types for the instruction fetch stage: FSM states, decode slot, NOP encoding.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus_4;
  } fetch_slot_t;

  // j/jal target: region bits come from the delay-slot PC+4 held in decode
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus_4,
                                              input logic [31:0] instr);
    return {pc_plus_4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction memory request/response bus between fetch (master) and imem (slave).
interface fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input  rvalid, rdata);
  modport slave  (input  req, addr, output rvalid, rdata);
endinterface

// File: rtl/fetch_instr_skid_buf.sv
// One-entry holding register for a fetched instruction that decode could not take yet.
module instr_skid_buf
  import pipeline_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_clear,
  input  fetch_slot_t i_slot,
  output logic        o_vld,
  output fetch_slot_t o_slot
);

  logic        r_vld;
  fetch_slot_t r_slot;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_vld  <= 1'b0;
      r_slot <= '0;
    end else if (i_clear) begin
      r_vld  <= 1'b0;
    end else if (i_load) begin
      r_vld  <= 1'b1;
      r_slot <= i_slot;
    end else if (i_drain) begin
      r_vld  <= 1'b0;
    end
  end

  assign o_vld  = r_vld;
  assign o_slot = r_slot;

endmodule

// File: rtl/fetch.sv
// MIPS fetch stage: one-outstanding imem requests, decode redirects, decode register.
// Optional FETCH_STATS_EN adds instruction / starvation-bubble counters.
module fetch
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_f_i,
  input  logic        stall_d_i,
  input  logic        flush_d_i,
  input  logic        pc_src_d_i,
  input  logic [31:0] pc_branch_d_i,
  input  logic [2:0]  jump_d_i,
  input  logic [31:0] jr_target_d_i,
  fetch_if.master     imem,
  output logic [31:0] instr_d_o,
  output logic [31:0] pc_plus_4_d_o,
  output logic        fetch_bubble_o
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] instr_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, r_req_pc;
  logic         w_redir, w_live, w_dec_ld, w_rsp_to_dec, w_issue;
  logic [31:0]  w_target;
  logic         w_buf_vld;
  fetch_slot_t  w_buf_slot, w_rsp_slot;
  logic         w_unused_link;

  // link bit only matters to the register-write path downstream
  assign w_unused_link = jump_d_i[2];

  assign w_redir = ~stall_f_i & (jump_d_i[1] | jump_d_i[0] | pc_src_d_i);

  always_comb begin
    w_target = pc_branch_d_i;
    if (jump_d_i[1])      w_target = jr_target_d_i;
    else if (jump_d_i[0]) w_target = jump_target(pc_plus_4_d_o, instr_d_o);
  end

  assign w_dec_ld     = ~stall_d_i & ~flush_d_i;
  assign w_live       = (r_state == WAIT) & imem.rvalid & ~w_redir;
  assign w_rsp_to_dec = w_live & ~w_buf_vld & w_dec_ld;
  assign w_rsp_slot   = '{instr: imem.rdata, pc_plus_4: r_req_pc + 32'd4};

  // gating on rst_i keeps the strobe low while reset is held
  assign w_issue = rst_i & ~stall_f_i & ~w_redir & ~w_buf_vld &
                   ((r_state == IDLE) |
                    ((r_state == WAIT) & imem.rvalid & w_rsp_to_dec));

  assign imem.req  = w_issue;
  assign imem.addr = r_pc;

  instr_skid_buf u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_load  (w_live & ~w_rsp_to_dec),
    .i_drain (w_buf_vld & w_dec_ld),
    .i_clear (w_redir),
    .i_slot  (w_rsp_slot),
    .o_vld   (w_buf_vld),
    .o_slot  (w_buf_slot)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_issue) w_state_nxt = WAIT;
      WAIT: begin
        if (w_redir)          w_state_nxt = imem.rvalid ? IDLE : DROP;
        else if (imem.rvalid) w_state_nxt = w_issue ? WAIT : IDLE;
      end
      DROP: if (imem.rvalid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
    end else if (w_redir) begin
      r_pc     <= w_target;
    end else if (w_issue) begin
      r_pc     <= r_pc + 32'd4;
      r_req_pc <= r_pc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instr_d_o      <= NOP_INSTR;
      pc_plus_4_d_o  <= '0;
      fetch_bubble_o <= 1'b0;
    end else if (!stall_d_i) begin
      if (flush_d_i) begin
        instr_d_o      <= NOP_INSTR;
        pc_plus_4_d_o  <= '0;
        fetch_bubble_o <= 1'b0;
      end else if (w_buf_vld) begin
        instr_d_o      <= w_buf_slot.instr;
        pc_plus_4_d_o  <= w_buf_slot.pc_plus_4;
        fetch_bubble_o <= 1'b0;
      end else if (w_live) begin
        instr_d_o      <= w_rsp_slot.instr;
        pc_plus_4_d_o  <= w_rsp_slot.pc_plus_4;
        fetch_bubble_o <= 1'b0;
      end else begin
        instr_d_o      <= NOP_INSTR;
        pc_plus_4_d_o  <= '0;
        fetch_bubble_o <= 1'b1;
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] r_instr_cnt, r_bubble_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_instr_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (w_dec_ld) begin
      if (w_buf_vld | w_live) r_instr_cnt  <= r_instr_cnt + 32'd1;
      else                    r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign instr_cnt_o  = r_instr_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch.sv
// Randomized self-checking bench for fetch against a queue-level model of the stage.
module tb_fetch;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f, stall_d, flush_d, pc_src;
  logic [31:0] pc_branch, jr_target;
  logic [2:0]  jump;
  logic [31:0] instr_d, pc4_d;
  logic        bubble_d;
`ifdef FETCH_STATS_EN
  logic [31:0] instr_cnt, bubble_cnt;
`endif

  fetch_if mem_if();

  fetch #(.RESET_PC(RPC)) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .stall_f_i      (stall_f),
    .stall_d_i      (stall_d),
    .flush_d_i      (flush_d),
    .pc_src_d_i     (pc_src),
    .pc_branch_d_i  (pc_branch),
    .jump_d_i       (jump),
    .jr_target_d_i  (jr_target),
    .imem           (mem_if),
    .instr_d_o      (instr_d),
    .pc_plus_4_d_o  (pc4_d),
    .fetch_bubble_o (bubble_d)
`ifdef FETCH_STATS_EN
    ,
    .instr_cnt_o    (instr_cnt),
    .bubble_cnt_o   (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // model: fetched-but-unconsumed instructions, memory with one pending request
  logic [63:0] m_q[$];
  logic [31:0] m_pc, m_instr, m_pc4, m_raddr, dmask;
  logic        m_bub, m_out, m_drop, exp_req, rv_now, last_req, obs_req;
  logic [31:0] obs_addr;
  int          m_cnt, lat, n_instr, n_bub;

  task automatic drive_idle();
    stall_f = 0; stall_d = 0; flush_d = 0; pc_src = 0;
    pc_branch = '0; jump = '0; jr_target = '0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive_idle();
    mem_if.rvalid = 1'b0;
    mem_if.rdata  = '0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_instr", instr_d, 32'h0);
      chk("rst_pc4",   pc4_d,   32'h0);
      chk("rst_bub",   32'(bubble_d), 32'h0);
      chk("rst_req",   32'(mem_if.req), 32'h0);
    end
    m_q.delete();
    m_pc = RPC; m_instr = 0; m_pc4 = 0; m_bub = 0;
    m_out = 0; m_drop = 0; m_cnt = 0; n_instr = 0; n_bub = 0;
    rst_n = 1'b1;
  endtask

  task automatic step();
    logic        redir, live, consumed;
    logic [31:0] tgt;
    logic [63:0] slot;
    rv_now = m_out && (m_cnt == 0);
    mem_if.rvalid = rv_now;
    mem_if.rdata  = rv_now ? (m_raddr ^ dmask) : 32'hDEAD_BEEF;
    redir = !stall_f && (jump[1] || jump[0] || pc_src);
    tgt = jump[1] ? jr_target : jump[0] ? {m_pc4[31:28], m_instr[25:0], 2'b00} : pc_branch;
    live = rv_now && !m_drop && !redir;
    exp_req = !stall_f && !redir && (m_q.size() == 0) &&
              (!m_out || (live && !stall_d && !flush_d));
    #1;
    obs_req  = mem_if.req;
    obs_addr = mem_if.addr;
    chk("req", 32'(obs_req), 32'(exp_req));
    if (exp_req) chk("addr", obs_addr, m_pc);
    last_req = exp_req;
    @(posedge clk);
    consumed = 0;
    if (!stall_d) begin
      if (flush_d) begin
        m_instr = 0; m_pc4 = 0; m_bub = 0;
      end else if (m_q.size() != 0) begin
        slot = m_q.pop_front();
        m_instr = slot[63:32]; m_pc4 = slot[31:0]; m_bub = 0; n_instr++;
      end else if (live) begin
        m_instr = m_raddr ^ dmask; m_pc4 = m_raddr + 32'd4; m_bub = 0;
        consumed = 1; n_instr++;
      end else begin
        m_instr = 0; m_pc4 = 0; m_bub = 1; n_bub++;
      end
    end
    if (live && !consumed) m_q.push_back({m_raddr ^ dmask, m_raddr + 32'd4});
    if (redir) m_q.delete();
    if (rv_now && m_drop)                m_drop = 0;
    else if (redir && m_out && !rv_now)  m_drop = 1;
    if (rv_now) m_out = 0;
    if (exp_req) begin
      m_out = 1; m_raddr = m_pc; m_cnt = lat - 1; m_pc = m_pc + 32'd4;
    end else if (m_out && m_cnt > 0) begin
      m_cnt--;
    end
    if (redir) m_pc = tgt;
    #1;
    chk("instr_d", instr_d, m_instr);
    chk("pc4_d",   pc4_d,   m_pc4);
    chk("bubble",  32'(bubble_d), 32'(m_bub));
`ifdef FETCH_STATS_EN
    chk("instr_cnt",  instr_cnt,  32'(n_instr));
    chk("bubble_cnt", bubble_cnt, 32'(n_bub));
`endif
  endtask

  task automatic run_until_req(input string tag);
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_req) return;
    end
    chk({tag, "_timeout"}, 32'h0, 32'h1);
  endtask

  int stall_reqs;
  int lat3_bubs;

  initial begin
    dmask = '0;
    lat   = 1;
    reset_dut();

    // back-to-back stream with single-cycle memory
    step();
    chk("first_req",  32'(obs_req), 32'h1);
    chk("first_addr", obs_addr, RPC);
    repeat (12) step();
    chk("lat1_instr", instr_d, 32'h2C);

    // three-cycle memory: two bubbles per instruction
    reset_dut();
    lat = 3;
    lat3_bubs = 0;
    repeat (12) begin
      step();
      if (bubble_d) lat3_bubs++;
    end
    chk("lat3_bubbles", 32'(lat3_bubs), 32'd9);

    // branch while the request to 0x10 is outstanding
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_req && obs_addr == 32'h10) break;
    end
    pc_src = 1; pc_branch = 32'h40;
    step();
    pc_src = 0;
    run_until_req("br");
    chk("br_target", obs_addr, 32'h40);

    // j using instr_d_o[25:0] = 0x40 from the fetched branch target
    for (int i = 0; i < 20; i++) begin
      if (m_instr == 32'h40 && !m_bub) break;
      step();
    end
    chk("j_src_instr", instr_d, 32'h40);
    jump = 3'b001;
    step();
    jump = 3'b000;
    run_until_req("j");
    chk("j_target", obs_addr, 32'h100);

    // jr
    reset_dut();
    lat = 2;
    repeat (3) step();
    jump = 3'b010; jr_target = 32'h100;
    step();
    jump = 3'b000;
    run_until_req("jr");
    chk("jr_target", obs_addr, 32'h100);
    repeat (4) step();

    // decode stall spanning a response
    reset_dut();
    lat = 2;
    step();
    step();
    stall_d = 1;
    stall_reqs = 0;
    repeat (4) begin
      step();
      if (obs_req) stall_reqs++;
    end
    stall_d = 0;
    chk("stall_noreq", 32'(stall_reqs), 32'h0);
    step();
    chk("stall_release", instr_d, 32'h0);
    chk("stall_rel_pc4", pc4_d, 32'h4);
    repeat (6) step();

    // randomized traffic with stalls, flushes and redirects
    reset_dut();
    dmask = 32'h5A5A_0000;
    for (int i = 0; i < 900; i++) begin
      if (i == 450) reset_dut();
      lat     = $urandom_range(1, 4);
      stall_d = ($urandom % 4) == 0;
      stall_f = ($urandom % 8) == 0;
      flush_d = ($urandom % 16) == 0;
      pc_src = 0; jump = 3'b000;
      if (($urandom % 24) == 0) begin
        case ($urandom % 3)
          0: begin pc_src = 1; pc_branch = {$urandom_range(0, 255), 2'b00}; end
          1: jump = 3'b001;
          default: begin jump = 3'b110; jr_target = {$urandom_range(0, 255), 2'b00}; end
        endcase
      end
      step();
    end
    drive_idle();
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch.md
# fetch

Instruction fetch stage of the five-stage MIPS pipeline and the producer side of the decode stage's instruction interface. It keeps the fetch PC and issues word requests to a variable-latency instruction memory, holding at most one request in flight. It applies redirects that decode resolves (branch, `j`/`jal`, `jr`) and drives the decode pipeline register (`instr_d_o`, `pc_plus_4_d_o`) under hazard-unit stall and flush control. When no instruction is ready, it inserts a NOP bubble.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-low reset.
- `stall_f_i`  in  1  freeze PC and suppress new requests.
- `stall_d_i`  in  1  hold the decode register.
- `flush_d_i`  in  1  load a bubble into the decode register.
- `pc_src_d_i`  in  1  branch taken in decode.
- `pc_branch_d_i`  in  32  branch target.
- `jump_d_i`  in  3  bit0 `j`/`jal`, bit1 `jr`, bit2 link (ignored here).
- `jr_target_d_i`  in  32  forwarded rs value for `jr`.
- `imem_req_o`  out  1  request strobe; always accepted by memory.
- `imem_addr_o`  out  32  word address of the request.
- `imem_rvalid_i`  in  1  response valid; arrives one or more cycles after its request, in order.
- `imem_rdata_i`  in  32  response instruction.
- `instr_d_o`  out  32  decode-stage instruction.
- `pc_plus_4_d_o`  out  32  decode-stage PC+4.
- `fetch_bubble_o`  out  1  decode register currently holds a fetch-starvation bubble.

## Operation
- Registers:
  - `pc_q`: next address to request.
  - `req_pc_q`: address of the outstanding request.
  - one-entry skid buffer holding `{instr, pc_plus_4}`.
  - FSM: `IDLE` (nothing outstanding), `WAIT` (outstanding, live), `DROP` (outstanding, stale).
- Redirect: `redir = ~stall_f_i & (jump_d_i[1] | jump_d_i[0] | pc_src_d_i)`.
- Redirect target priority:
  - `jr`: `jr_target_d_i`.
  - `j`/`jal`: `{pc_plus_4_d_o[31:28], instr_d_o[25:0], 2'b00}`.
  - branch: `pc_branch_d_i`.
- Issue condition: `~stall_f_i & ~redir`, the buffer is empty, and either state is `IDLE` or state is `WAIT` with `imem_rvalid_i` high whose data goes straight to decode this cycle.
- On issue:
  - `imem_addr_o = pc_q`.
  - `req_pc_q <= pc_q`.
  - `pc_q <= pc_q + 4` (modulo 2^32).
  - state becomes `WAIT`.
- On redirect:
  - `pc_q <= target`.
  - buffer cleared.
  - any response arriving this cycle is discarded.
  - state goes `WAIT`→`DROP` when no response arrives this cycle, otherwise `IDLE`.
  - no request is issued in the redirect cycle.
- In `DROP`: the next `imem_rvalid_i` is discarded and state goes to `IDLE`.
- Live response in `WAIT` without redirect: `{imem_rdata_i, req_pc_q + 4}` goes to decode when the decode register loads this cycle and the buffer is empty; otherwise it goes into the buffer.
- Decode register update, in priority order:
  1. `stall_d_i`: hold.
  2. `flush_d_i`: NOP (`32'h0`), `pc_plus_4 = 0`, `fetch_bubble_o = 0`.
  3. Buffer valid: load the buffer.
  4. Live response: load the response.
  5. Otherwise: NOP with `fetch_bubble_o = 1`.

## Timing
- Reset:
  - `pc_q = RESET_PC`, state `IDLE`, buffer empty.
  - `instr_d_o = 0`, `pc_plus_4_d_o = 0`, `fetch_bubble_o = 0`, `imem_req_o = 0`.
  - First request in the first cycle after `rst_i` rises.
- Reset asserted mid-request: the state is abandoned. A late `imem_rvalid_i` arriving in `IDLE` is ignored.
- Memory with 1-cycle latency: one instruction per cycle, because the next request issues in the same cycle the response is consumed.
- Memory with N-cycle latency: one instruction every N cycles, with N−1 bubbles between them.
- Response to decode output: the response is visible on `instr_d_o` at the next edge. Request-to-decode latency is N cycles.
- Stall during a response: data lands in the buffer. No request issues until the buffer drains, which happens on the first cycle with `stall_d_i` low.
- Redirect to target fetch:
  - target request issues the cycle after the redirect, or after the `DROP` response arrives if a request was outstanding.
  - The wrong-path instruction is removed by the hazard unit's `flush_d_i`.

## Configuration
- `FETCH_STATS_EN` defined:
  - adds output `instr_cnt_o` [31:0], counting decode loads of real instructions.
  - adds output `bubble_cnt_o` [31:0], counting starvation bubbles.
  - both reset to 0 and wrap modulo 2^32.
- `FETCH_STATS_EN` undefined: the ports and counters are absent.

## Structure
- `pipeline_pkg` holds:
  - `NOP_INSTR = 32'h0000_0000`.
  - `fetch_state_e` {`IDLE`, `WAIT`, `DROP`}.
  - `fetch_slot_t` struct `{instr, pc_plus_4}`.
- One sub-module, `instr_skid_buf`: one-entry valid/data holding register with load, drain and clear inputs.

## Test plan
- Reset held low for 3 cycles → all outputs 0. After release, `imem_req_o = 1` with `imem_addr_o = RESET_PC` in the first cycle.
- Memory with 1-cycle latency returning `addr` as data → `instr_d_o` shows 0, 4, 8, … on consecutive cycles; `pc_plus_4_d_o` = data + 4; `fetch_bubble_o` stays 0.
- Memory with 3-cycle latency → one instruction every 3 cycles, 2 bubble cycles between them with `fetch_bubble_o = 1`.
- `pc_src_d_i = 1`, `pc_branch_d_i = 32'h40` while a request to 0x10 is outstanding → the 0x10 response is dropped and the next `imem_addr_o` is 0x40.
- `stall_d_i` high for 4 cycles while a response returns → no new request issues; the instruction appears one cycle after the stall drops; none are lost or duplicated.
- `jump_d_i = 3'b010` with `jr_target_d_i = 32'h100` → next address 0x100. `jump_d_i = 3'b001` with `instr_d_o[25:0] = 26'h40` → next address 0x100 (upper four PC bits zero).
